// File: rtl/neural_layer_sequencer.sv
// Multi-layer fully-connected network sequencer.
// Fetches per-layer neuron counts, runs the signed fixed-point MAC per neuron,
// rescales and saturates the result, applies optional hidden-layer ReLU and writes
// activations back to the neuron RAM. Memories have one cycle of read latency.
module neural_layer_sequencer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned ACC_W       = 20,
  parameter int unsigned FRAC_BITS   = 4,
  parameter int unsigned RELU_HIDDEN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_inputs,
  input  logic [ADDR_W-1:0] num_layers,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [DATA_W-1:0] weight_data,
  output logic [ADDR_W-1:0] nrd_addr,
  input  logic [DATA_W-1:0] nrd_data,
  output logic              nwr_en,
  output logic [ADDR_W-1:0] nwr_addr,
  output logic [DATA_W-1:0] nwr_data,
  output logic [ADDR_W-1:0] result_base,
  output logic [ADDR_W-1:0] result_count
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_MAC, S_DRAIN, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [ADDR_W-1:0]        r_in_cnt;
  logic [ADDR_W-1:0]        r_layers;
  logic [ADDR_W-1:0]        r_ip;
  logic [ADDR_W-1:0]        r_rd_base;
  logic [ADDR_W-1:0]        r_wr_base;
  logic [ADDR_W-1:0]        r_w_ptr;
  logic [ADDR_W-1:0]        r_nk;
  logic [ADDR_W-1:0]        r_neuron;
  logic [ADDR_W-1:0]        r_i;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_error;
  logic [ADDR_W-1:0]        r_result_base;
  logic [ADDR_W-1:0]        r_result_count;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_add;
  logic signed [ACC_W-1:0]  w_shifted;
  logic signed [DATA_W-1:0] w_sat;
  logic signed [DATA_W-1:0] w_act;
  logic                     w_start_ok;
  logic                     w_mac_last;
  logic                     w_last_neuron;
  logic                     w_last_layer;

  assign w_prod        = PROD_W'($signed(nrd_data)) * PROD_W'($signed(weight_data));
  assign w_acc_add     = r_acc + ACC_W'(w_prod);
  assign w_start_ok    = (n_inputs != '0) && (num_layers != '0);
  assign w_mac_last    = (r_i == r_in_cnt - ADDR_W'(1));
  assign w_last_neuron = (r_neuron == r_nk - ADDR_W'(1));
  assign w_last_layer  = (r_ip == r_layers - ADDR_W'(1));

  assign error        = r_error;
  assign result_base  = r_result_base;
  assign result_count = r_result_count;

  // Rescale, saturate and (for hidden layers) rectify the accumulator
  always_comb begin
    w_shifted = r_acc >>> FRAC_BITS;
    if (w_shifted > SAT_MAX) begin
      w_sat = DATA_W'(SAT_MAX);
    end else if (w_shifted < SAT_MIN) begin
      w_sat = DATA_W'(SAT_MIN);
    end else begin
      w_sat = DATA_W'(w_shifted);
    end
    w_act = w_sat;
    if ((RELU_HIDDEN != 0) && !w_last_layer && w_sat[DATA_W-1]) begin
      w_act = '0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_start_ok ? S_FETCH : S_DONE;
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = (instr_data == '0) ? S_DONE : S_MAC;
      S_MAC:   if (w_mac_last) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_last_neuron ? S_NEXT : S_MAC;
      S_NEXT:  w_state_nxt = w_last_layer ? S_DONE : S_FETCH;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: memory addresses, write strobe and handshake
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    instr_addr  = '0;
    weight_addr = '0;
    nrd_addr    = '0;
    nwr_en      = 1'b0;
    nwr_addr    = '0;
    nwr_data    = '0;
    case (r_state)
      S_IDLE:  ;
      S_DONE:  done = 1'b1;
      default: busy = 1'b1;
    endcase
    case (r_state)
      S_FETCH: instr_addr = r_ip;
      S_MAC: begin
        nrd_addr    = r_rd_base + r_i;
        weight_addr = r_w_ptr + r_i;
      end
      S_WRITE: begin
        nwr_en   = 1'b1;
        nwr_addr = r_wr_base + r_neuron;
        nwr_data = w_act;
      end
      default: ;
    endcase
  end

  // Datapath: counters, bases, accumulator and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_cnt       <= '0;
      r_layers       <= '0;
      r_ip           <= '0;
      r_rd_base      <= '0;
      r_wr_base      <= '0;
      r_w_ptr        <= '0;
      r_nk           <= '0;
      r_neuron       <= '0;
      r_i            <= '0;
      r_acc          <= '0;
      r_error        <= 1'b0;
      r_result_base  <= '0;
      r_result_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_start_ok) begin
              r_in_cnt  <= n_inputs;
              r_layers  <= num_layers;
              r_ip      <= '0;
              r_rd_base <= '0;
              r_wr_base <= n_inputs;
              r_w_ptr   <= '0;
              r_error   <= 1'b0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_nk     <= ADDR_W'(instr_data);
          r_neuron <= '0;
          r_acc    <= '0;
          r_i      <= '0;
          if (instr_data == '0) r_error <= 1'b1;
        end
        S_MAC: begin
          // First MAC cycle has no returned data yet
          if (r_i != '0) r_acc <= w_acc_add;
          if (!w_mac_last) r_i <= r_i + ADDR_W'(1);
        end
        S_DRAIN: r_acc <= w_acc_add;
        S_WRITE: begin
          r_acc   <= '0;
          r_i     <= '0;
          r_w_ptr <= r_w_ptr + r_in_cnt;
          if (!w_last_neuron) r_neuron <= r_neuron + ADDR_W'(1);
        end
        S_NEXT: begin
          r_rd_base <= r_wr_base;
          r_wr_base <= r_wr_base + r_nk;
          r_in_cnt  <= r_nk;
          r_ip      <= r_ip + ADDR_W'(1);
          if (w_last_layer) begin
            r_result_base  <= r_wr_base;
            r_result_count <= r_nk;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_layer_sequencer.sv
// Directed bench for neural_layer_sequencer: two instances (hidden ReLU on/off)
// with behavioural instruction RAM, weight ROM and neuron RAMs.
module tb_neural_layer_sequencer;

  logic clk;
  logic reset;
  logic start_a, start_b;
  logic [7:0] n_inputs, num_layers;

  logic       busy_a, done_a, error_a, nwr_en_a;
  logic [7:0] instr_addr_a, weight_addr_a, nrd_addr_a, nwr_addr_a, nwr_data_a;
  logic [7:0] result_base_a, result_count_a;
  logic [7:0] instr_q_a, weight_q_a, nrd_q_a;

  logic       busy_b, done_b, error_b, nwr_en_b;
  logic [7:0] instr_addr_b, weight_addr_b, nrd_addr_b, nwr_addr_b, nwr_data_b;
  logic [7:0] result_base_b, result_count_b;
  logic [7:0] instr_q_b, weight_q_b, nrd_q_b;

  logic [7:0] instr_mem [256];
  logic [7:0] w_mem [256];
  logic [7:0] nram_a [256];
  logic [7:0] nram_b [256];
  logic       tb_we;
  logic [7:0] tb_wa, tb_wd;

  logic [7:0] wr_addr_a [$];
  logic [7:0] wr_data_a [$];
  logic [7:0] wr_addr_b [$];
  logic [7:0] wr_data_b [$];

  logic [7:0] wlog [64];
  logic [7:0] rlog [64];
  logic       blog [64];

  int vectors;
  int miscompares;

  neural_layer_sequencer #(.RELU_HIDDEN(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .n_inputs(n_inputs), .num_layers(num_layers),
    .busy(busy_a), .done(done_a), .error(error_a),
    .instr_addr(instr_addr_a), .instr_data(instr_q_a),
    .weight_addr(weight_addr_a), .weight_data(weight_q_a),
    .nrd_addr(nrd_addr_a), .nrd_data(nrd_q_a),
    .nwr_en(nwr_en_a), .nwr_addr(nwr_addr_a), .nwr_data(nwr_data_a),
    .result_base(result_base_a), .result_count(result_count_a)
  );

  neural_layer_sequencer #(.RELU_HIDDEN(0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .n_inputs(n_inputs), .num_layers(num_layers),
    .busy(busy_b), .done(done_b), .error(error_b),
    .instr_addr(instr_addr_b), .instr_data(instr_q_b),
    .weight_addr(weight_addr_b), .weight_data(weight_q_b),
    .nrd_addr(nrd_addr_b), .nrd_data(nrd_q_b),
    .nwr_en(nwr_en_b), .nwr_addr(nwr_addr_b), .nwr_data(nwr_data_b),
    .result_base(result_base_b), .result_count(result_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories and write logging
  always @(posedge clk) begin
    instr_q_a  <= instr_mem[instr_addr_a];
    weight_q_a <= w_mem[weight_addr_a];
    nrd_q_a    <= nram_a[nrd_addr_a];
    instr_q_b  <= instr_mem[instr_addr_b];
    weight_q_b <= w_mem[weight_addr_b];
    nrd_q_b    <= nram_b[nrd_addr_b];
    if (nwr_en_a) begin
      nram_a[nwr_addr_a] <= nwr_data_a;
      wr_addr_a.push_back(nwr_addr_a);
      wr_data_a.push_back(nwr_data_a);
    end
    if (nwr_en_b) begin
      nram_b[nwr_addr_b] <= nwr_data_b;
      wr_addr_b.push_back(nwr_addr_b);
      wr_data_b.push_back(nwr_data_b);
    end
    if (tb_we) begin
      nram_a[tb_wa] <= tb_wd;
      nram_b[tb_wa] <= tb_wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_n(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Start one instance and wait (bounded) for done; cyc = edges after the start edge
  task automatic run(input bit sel, input logic [7:0] nin, input logic [7:0] nl,
                     input int pulse_at, output int cyc);
    n_inputs   = nin;
    num_layers = nl;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    cyc = 0;
    while (((sel ? done_b : done_a) !== 1'b1) && cyc < 200) begin
      if (cyc < 64) begin
        wlog[cyc] = weight_addr_a;
        rlog[cyc] = nrd_addr_a;
        blog[cyc] = busy_a;
      end
      start_a = (!sel && cyc == pulse_at);
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
  endtask

  initial begin
    int cyc;
    int n0;
    int pos [8];
    logic [7:0] exp_rd [8];
    vectors     = 0;
    miscompares = 0;
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    tb_we   = 1'b0;
    tb_wa   = '0;
    tb_wd   = '0;
    n_inputs   = '0;
    num_layers = '0;
    for (int i = 0; i < 256; i++) begin
      instr_mem[i] = '0;
      w_mem[i]     = '0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_error", error_a, 0);
    check("rst_nwr_en", nwr_en_a, 0);
    check("rst_result_base", result_base_a, 0);
    check("rst_result_count", result_count_a, 0);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b1;
    @(negedge clk);

    // Test 1: 1.0*1.0 + 2.0*1.0 = 3.0 (48 in Q4.4)
    instr_mem[0] = 8'd1;
    w_mem[0] = 8'd16;
    w_mem[1] = 8'd16;
    load_n(8'd0, 8'd16);
    load_n(8'd1, 8'd32);
    n0 = wr_addr_a.size();
    run(1'b0, 8'd2, 8'd1, -1, cyc);
    check("t1_done", done_a, 1);
    check("t1_cycles", cyc, 7);
    check("t1_busy_first", blog[0], 1);
    check("t1_nwrites", wr_addr_a.size() - n0, 1);
    check("t1_waddr", wr_addr_a[n0], 8'd2);
    check("t1_wdata", wr_data_a[n0], 8'd48);
    check("t1_result_base", result_base_a, 8'd2);
    check("t1_result_count", result_count_a, 8'd1);
    check("t1_error", error_a, 0);
    @(negedge clk);
    check("t1_idle_busy", busy_a, 0);
    check("t1_idle_done", done_a, 0);

    // Test 2: positive and negative saturation
    load_n(8'd0, 8'd127);
    load_n(8'd1, 8'd127);
    w_mem[0] = 8'd127;
    w_mem[1] = 8'd127;
    n0 = wr_addr_a.size();
    run(1'b0, 8'd2, 8'd1, -1, cyc);
    check("t2_done", done_a, 1);
    check("t2_sat_pos", wr_data_a[n0], 8'h7F);
    @(negedge clk);
    w_mem[0] = 8'h80;
    w_mem[1] = 8'h80;
    n0 = wr_addr_a.size();
    run(1'b0, 8'd2, 8'd1, -1, cyc);
    check("t2b_done", done_a, 1);
    check("t2_sat_neg", wr_data_a[n0], 8'h80);
    @(negedge clk);

    // Test 3: hidden acc = 16*(-32) = -512 -> -32; ReLU on instance a only
    instr_mem[0] = 8'd1;
    instr_mem[1] = 8'd1;
    w_mem[0] = 8'hE0;
    w_mem[1] = 8'd16;
    load_n(8'd0, 8'd16);
    n0 = wr_addr_a.size();
    run(1'b0, 8'd1, 8'd2, -1, cyc);
    check("t3_done", done_a, 1);
    check("t3_cycles", cyc, 12);
    check("t3_nwrites", wr_addr_a.size() - n0, 2);
    check("t3_hid_addr", wr_addr_a[n0], 8'd1);
    check("t3_hid_relu", wr_data_a[n0], 8'd0);
    check("t3_out_addr", wr_addr_a[n0+1], 8'd2);
    check("t3_out_data", wr_data_a[n0+1], 8'd0);
    check("t3_result_base", result_base_a, 8'd2);
    @(negedge clk);
    n0 = wr_addr_b.size();
    run(1'b1, 8'd1, 8'd2, -1, cyc);
    check("t3b_done", done_b, 1);
    check("t3b_cycles", cyc, 12);
    check("t3b_nwrites", wr_addr_b.size() - n0, 2);
    check("t3b_hid_data", wr_data_b[n0], 8'hE0);
    check("t3b_out_addr", wr_addr_b[n0+1], 8'd2);
    check("t3b_out_data", wr_data_b[n0+1], 8'hE0);
    check("t3b_result_base", result_base_b, 8'd2);
    check("t3b_result_count", result_count_b, 8'd1);
    check("t3b_error", error_b, 0);
    @(negedge clk);
    check("t3b_idle_busy", busy_b, 0);

    // Test 4: addressing, 3 inputs, layers Nk={2,1}
    instr_mem[0] = 8'd2;
    instr_mem[1] = 8'd1;
    w_mem[0] = 8'd16; w_mem[1] = 8'd0;  w_mem[2] = 8'd0;
    w_mem[3] = 8'd0;  w_mem[4] = 8'd16; w_mem[5] = 8'd16;
    w_mem[6] = 8'd16; w_mem[7] = 8'd16;
    load_n(8'd0, 8'd16);
    load_n(8'd1, 8'd16);
    load_n(8'd2, 8'd16);
    n0 = wr_addr_a.size();
    run(1'b0, 8'd3, 8'd2, -1, cyc);
    check("t4_done", done_a, 1);
    check("t4_cycles", cyc, 20);
    check("t4_nwrites", wr_addr_a.size() - n0, 3);
    check("t4_w0_addr", wr_addr_a[n0], 8'd3);
    check("t4_w0_data", wr_data_a[n0], 8'd16);
    check("t4_w1_addr", wr_addr_a[n0+1], 8'd4);
    check("t4_w1_data", wr_data_a[n0+1], 8'd32);
    check("t4_w2_addr", wr_addr_a[n0+2], 8'd5);
    check("t4_w2_data", wr_data_a[n0+2], 8'd48);
    check("t4_result_base", result_base_a, 8'd5);
    check("t4_result_count", result_count_a, 8'd1);
    pos    = '{2, 3, 4, 7, 8, 9, 15, 16};
    exp_rd = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_weight_addr%0d", k), wlog[pos[k]], k);
      check($sformatf("t4_nrd_addr%0d", k), rlog[pos[k]], exp_rd[k]);
    end
    @(negedge clk);

    // Test 5: Nk==0 at ip=1 aborts after layer 0
    instr_mem[0] = 8'd1;
    instr_mem[1] = 8'd0;
    w_mem[0] = 8'd16;
    w_mem[1] = 8'd16;
    load_n(8'd0, 8'd16);
    load_n(8'd1, 8'd32);
    n0 = wr_addr_a.size();
    run(1'b0, 8'd2, 8'd2, -1, cyc);
    check("t5_done", done_a, 1);
    check("t5_cycles", cyc, 9);
    check("t5_error", error_a, 1);
    check("t5_nwrites", wr_addr_a.size() - n0, 1);
    check("t5_wdata", wr_data_a[n0], 8'd48);
    @(negedge clk);
    check("t5_error_sticky", error_a, 1);
    n0 = wr_addr_a.size();
    run(1'b0, 8'd2, 8'd0, -1, cyc);
    check("t5b_done", done_a, 1);
    check("t5b_cycles", cyc, 0);
    check("t5b_error", error_a, 1);
    check("t5b_nwrites", wr_addr_a.size() - n0, 0);
    @(negedge clk);
    run(1'b0, 8'd0, 8'd1, -1, cyc);
    check("t5c_cycles", cyc, 0);
    check("t5c_error", error_a, 1);
    @(negedge clk);

    // Test 6a: start pulse during busy is ignored; good start clears error
    instr_mem[0] = 8'd1;
    n0 = wr_addr_a.size();
    run(1'b0, 8'd2, 8'd1, 3, cyc);
    check("t6_cycles", cyc, 7);
    check("t6_error_cleared", error_a, 0);
    check("t6_nwrites", wr_addr_a.size() - n0, 1);
    check("t6_wdata", wr_data_a[n0], 8'd48);
    @(negedge clk);
    @(negedge clk);
    check("t6_no_restart", busy_a, 0);

    // Test 6b: reset mid-MAC aborts immediately
    n0 = wr_addr_a.size();
    n_inputs   = 8'd2;
    num_layers = 8'd1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6b_busy_pre", busy_a, 1);
    reset = 1'b0;
    #1;
    check("t6b_busy", busy_a, 0);
    check("t6b_done", done_a, 0);
    check("t6b_nwr_en", nwr_en_a, 0);
    repeat (10) @(negedge clk);
    check("t6b_nwrites", wr_addr_a.size() - n0, 0);
    reset = 1'b1;
    @(negedge clk);

    // Re-run of test 1 after reset
    n0 = wr_addr_a.size();
    run(1'b0, 8'd2, 8'd1, -1, cyc);
    check("t6c_done", done_a, 1);
    check("t6c_cycles", cyc, 7);
    check("t6c_waddr", wr_addr_a[n0], 8'd2);
    check("t6c_wdata", wr_data_a[n0], 8'd48);
    check("t6c_result_base", result_base_a, 8'd2);
    check("t6c_result_count", result_count_a, 8'd1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
